// File: rtl/bidir_xcvr_reg.sv
// Registered bidirectional transceiver between tri-state buses a and b.
// Direction or enable changes pass through a tri-stated turnaround window.
module bidir_xcvr_reg #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             control,
   inout  wire  [WIDTH-1:0] a,
   inout  wire  [WIDTH-1:0] b,
   output logic             dir_q,
   output logic             active,
   output logic             busy,
   output logic [CNT_W-1:0] swap_cnt
);

   typedef enum logic [1:0] {S_OFF, S_TURN, S_A2B, S_B2A} state_t;

   localparam int TC_INIT = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

   state_t           state_q, state_d;
   logic             tgt_q, tgt_d;
   logic [3:0]       tc_q, tc_d;
   logic [WIDTH-1:0] data_q;
   logic             enter;

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      tc_d    = tc_q;
      case (state_q)
         S_OFF: begin
            if (en) begin
               if (TURN_CYCLES == 0) begin
                  state_d = control ? S_A2B : S_B2A;
               end else begin
                  state_d = S_TURN;
                  tgt_d   = control;
                  tc_d    = 4'(TC_INIT);
               end
            end
         end
         S_TURN: begin
            // control is deliberately ignored here; tgt was latched on entry
            if (!en)
               state_d = S_OFF;
            else if (tc_q == 4'd0)
               state_d = tgt_q ? S_A2B : S_B2A;
            else
               tc_d = tc_q - 4'd1;
         end
         S_A2B, S_B2A: begin
            if (!en) begin
               state_d = S_OFF;
            end else if (control != (state_q == S_A2B)) begin
               if (TURN_CYCLES == 0) begin
                  state_d = control ? S_A2B : S_B2A;
               end else begin
                  state_d = S_TURN;
                  tgt_d   = control;
                  tc_d    = 4'(TC_INIT);
               end
            end
         end
         default: state_d = S_OFF;
      endcase
   end

   assign enter = ((state_d == S_A2B) || (state_d == S_B2A)) && (state_d != state_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_OFF;
         tgt_q    <= 1'b0;
         tc_q     <= 4'd0;
         data_q   <= '0;
         dir_q    <= 1'b0;
         swap_cnt <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         tc_q    <= tc_d;
         // Source bus is sampled raw, so the first driven word equals the entry-edge source
         if (state_d == S_A2B) begin
            data_q <= a;
            dir_q  <= 1'b1;
         end else if (state_d == S_B2A) begin
            data_q <= b;
            dir_q  <= 1'b0;
         end
         if (enter && (swap_cnt != {CNT_W{1'b1}}))
            swap_cnt <= swap_cnt + 1'b1;
      end
   end

   // Pad enables come from registered state only
   assign b      = (state_q == S_A2B) ? data_q : {WIDTH{1'bz}};
   assign a      = (state_q == S_B2A) ? data_q : {WIDTH{1'bz}};
   assign active = (state_q == S_A2B) || (state_q == S_B2A);
   assign busy   = (state_q == S_TURN);

endmodule

// File: doc/bidir_xcvr_reg.md
Name: bidir_xcvr_reg

Overview:
Parametrised, clocked bidirectional transceiver joining two shared tri-state buses, a and b, WIDTH bits each. Data is registered, giving one clock of latency in the selected direction. A direction change inserts a programmable turnaround window in which neither side is driven, so the two sides never drive at the same time. It replaces direct combinational direction switching at bus-bridge points and counts completed direction changes.

Parameters:
WIDTH, 8, data width of a and b.
TURN_CYCLES, 2, number of clocks with both sides tri-stated on any enable or direction change; legal range 0..15.
CNT_W, 16, width of the direction-change counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
en  input  1  1 = transceiver active; 0 = both sides tri-stated.
control  input  1  requested direction: 1 = a drives b (A2B), 0 = b drives a (B2A).
a  inout  WIDTH  side-A bus; driven only in B2A.
b  inout  WIDTH  side-B bus; driven only in A2B.
dir_q  output  1  direction currently in effect; meaningful only when active = 1.
active  output  1  1 when in state A2B or B2A.
busy  output  1  1 while in state TURN.
swap_cnt  output  CNT_W  saturating count of completed entries into A2B or B2A.

Behaviour:
- Reset (rst = 1 at an edge):
  - state OFF; data_q = 0; dir_q = 0; active = 0; busy = 0; swap_cnt = 0.
  - a and b both Z from the cycle after the reset edge.
- Reset overrides every other input, including a reset during TURN.
- State machine: states OFF, TURN, A2B, B2A; a target register tgt and a turnaround counter tc.
- Transitions from OFF:
  - en = 1, TURN_CYCLES > 0: go to TURN; tgt = control; tc = TURN_CYCLES - 1.
  - en = 1, TURN_CYCLES = 0: go directly to A2B if control = 1, else B2A.
- Transitions from TURN:
  - en = 0: go to OFF.
  - tc = 0: go to A2B if tgt = 1, else B2A.
  - otherwise: tc decrements.
  - control is ignored while in TURN; tgt is latched at TURN entry.
- Transitions from A2B or B2A:
  - en = 0: go to OFF; the next cycle is Z on both sides.
  - control differs from the current direction: go to TURN with tgt = control (or switch directly when TURN_CYCLES = 0).
  - otherwise: stay.
- A control change made during TURN is acted on after arrival at the target: a second turnaround starts the cycle after arrival. No glitch state is permitted.
- TURN length is exactly TURN_CYCLES clocks with a = b = Z.
- Drive:
  - b = data_q when state = A2B, else Z.
  - a = data_q when state = B2A, else Z.
  - Output enables are decoded from registered state only; no combinational path exists from control or en to the pad enables.
- Data register:
  - At every edge where next state is A2B, data_q <= a.
  - At every edge where next state is B2A, data_q <= b.
  - Otherwise data_q holds its value.
  - Result: 1-clock latency source-to-destination, and the first driven value on entry equals the source sampled at the entry edge.
  - A Z or X on the source is sampled as-is; no filtering.
- dir_q updates on entry to A2B (1) or B2A (0); it holds through TURN and OFF.
- active and busy are Moore decodes of state.
- swap_cnt increments by 1 on each edge entering A2B or B2A from OFF or TURN, including direct entries when TURN_CYCLES = 0. It saturates at all-ones and does not wrap.
- Invariant: a and b are never driven in the same cycle.

Test Plan:
- Reset then idle: rst = 1 for 2 clocks, en = 0 -> a = b = Z, swap_cnt = 0, active = 0, busy = 0 for 10 clocks.
- Enable A2B: en = 1, control = 1, bench drives a = 8'hA5 -> busy = 1 for exactly 2 clocks with b = Z; then active = 1, dir_q = 1, b = 8'hA5, swap_cnt = 1. Then a = 8'h3C -> b = 8'h3C one clock later.
- Turnaround A2B to B2A: control drops to 0, bench releases a, drives b = 8'h5A -> next cycle a = b = Z for 2 clocks, never both driven; then a = 8'h5A, dir_q = 0, swap_cnt = 2.
- Direction flip during TURN: control toggles 1->0->1 inside the turnaround window -> state reaches the latched tgt; the next cycle starts a second 2-clock TURN; final direction = 1; swap_cnt increments twice.
- Disable and mid-operation reset:
  - en = 0 in A2B -> b = Z the next cycle, state OFF, dir_q holds.
  - rst = 1 during TURN -> OFF, swap_cnt = 0, data_q = 0.
- Parameter variants:
  - TURN_CYCLES = 0, WIDTH = 16: control toggles every 5 clocks -> direct switch with no Z window, data_q tracks the new source with 1-clock latency.
  - CNT_W = 2: after 5 swaps, swap_cnt = 2'b11 (saturated).
